cache_req_arbiter: RTL

Round-robin front-end that shares one `cacheSim` instance between `NUM_REQ` trace/CPU requesters. It accepts one request at a time over a valid/ready handshake and drives it into the cache's `rw`/`address` inputs. It then waits for the cache to finish the access and routes the hit/miss result back to the originating requester. It sits between the trace-driving logic and `cacheSim`, and keeps per-requester grant counters for the statistics report.

---
 rtl/cache_pkg.sv | 11 +
 rtl/rr_picker.sv | 30 +++
 rtl/cache_req_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types for the cache request arbiter slice
package cache_pkg;

  typedef logic [15:0] u16;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

  localparam int DEF_ADDRESS_SIZE = 16;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at ptr
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] id,
  output logic          any
);

  int j;

  // Walk from the farthest offset down so the closest valid requester wins last.
  always_comb begin
    onehot = '0;
    id     = '0;
    any    = |req;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        onehot = N'(1) << j;
        id     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - shares one cache port between NUM_REQ requesters
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cache_valid,
  output logic                         rw,
  output logic [ADDRESS_SIZE-1:0]      address,
  input  logic                         cache_ready,
  input  logic                         cache_done,
  input  logic                         cache_hit,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic                         resp_hit,
  output logic [NUM_REQ*32-1:0]        grant_count,
  output logic                         protocol_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t              state;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           cur_id;
  logic [NUM_REQ-1:0]      win_oh;
  logic [IW-1:0]           win_id;
  logic                    win_any;
  u32 [NUM_REQ-1:0]        grant_cnt;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .id     (win_id),
    .any    (win_any)
  );

  assign req_ready   = (state == IDLE) ? win_oh : '0;
  assign grant_count = grant_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      cache_valid  <= 1'b0;
      rw           <= 1'b0;
      address      <= '0;
      resp_valid   <= '0;
      resp_hit     <= 1'b0;
      grant_cnt    <= '0;
      protocol_err <= 1'b0;
    end else begin
      resp_valid <= '0;
      resp_hit   <= 1'b0;
      // A completion with nothing outstanding is flagged and otherwise dropped.
      if (cache_done && state != WAIT) begin
        protocol_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (win_any) begin
            rw                <= req_rw[win_id];
            address           <= req_addr[int'(win_id)*ADDRESS_SIZE +: ADDRESS_SIZE];
            cur_id            <= win_id;
            rr_ptr            <= (win_id == IW'(NUM_REQ - 1)) ? '0 : win_id + IW'(1);
            grant_cnt[win_id] <= grant_cnt[win_id] + 32'd1;
            cache_valid       <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (cache_ready) begin
            cache_valid <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cache_done) begin
            resp_valid <= NUM_REQ'(1) << cur_id;
            resp_hit   <= cache_hit;
            state      <= IDLE;
          end
        end
        default: begin
          cache_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
